vga_frame_reader: RTL

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

---
 rtl/vga_frame_reader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 2x2 nearest-neighbour upscaler fetching RGB444 from a framebuffer; RD_LAT+1 cycle latency, no backpressure (locked to pixel clock).
// Optional build macro VGA_TEST_PATTERN_EN adds pattern_sel, replacing framebuffer data with eight vertical colour bars.
module vga_frame_reader #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       pixel_x,
  input  logic [11:0]       pixel_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [11:0]       fb_rd_data,
  output logic [11:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              video_on_out,
  output logic              frame_start
);

  localparam int D = RD_LAT + 1;
  localparam logic [11:0] DST_W = 12'(2 * SRC_W);
  localparam logic [11:0] DST_H = 12'(2 * SRC_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((SRC_H - 1) * SRC_W);

  typedef enum logic {SYNC_WAIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] row_base;
  logic [D-1:0]      hs_sr, vs_sr, vo_sr, run_sr, fs_sr;
  logic              at_origin, run_eff, in_area;
  logic [11:0]       src;

  // The (0,0) cycle that moves the FSM into RUN already counts as running,
  // so the first pixel of the first frame is fetched and shown.
  assign at_origin = (pixel_x == 12'd0) && (pixel_y == 12'd0);
  assign run_eff   = (state == RUN) || at_origin;
  assign in_area   = (pixel_x < DST_W) && (pixel_y < DST_H);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (2 * SRC_W) / 8;

  logic [2:0]        bar_idx;
  logic [2:0]        bar_sr [RD_LAT];
  logic [RD_LAT-1:0] pat_sr;

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 12'hFFF;
      3'd1:    bar_color = 12'hFF0;
      3'd2:    bar_color = 12'h0FF;
      3'd3:    bar_color = 12'h0F0;
      3'd4:    bar_color = 12'hF0F;
      3'd5:    bar_color = 12'hF00;
      3'd6:    bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++)
      if (pixel_x >= 12'(k * BAR_W)) bar_idx = 3'(k);
  end

  // Bar index and select travel RD_LAT stages so they meet the fb data slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_sr <= '0;
      for (int k = 0; k < RD_LAT; k++) bar_sr[k] <= 3'd0;
    end else begin
      pat_sr[0] <= pattern_sel;
      bar_sr[0] <= bar_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        pat_sr[k] <= pat_sr[k-1];
        bar_sr[k] <= bar_sr[k-1];
      end
    end
  end

  assign src      = pat_sr[RD_LAT-1] ? bar_color(bar_sr[RD_LAT-1]) : fb_rd_data;
  assign fb_rd_en = !rst && run_eff && video_on && in_area && !pattern_sel;
`else
  assign src      = fb_rd_data;
  assign fb_rd_en = !rst && run_eff && video_on && in_area;
`endif

  assign fb_rd_addr = fb_rd_en ? (row_base + ADDR_W'(pixel_x[11:1])) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC_WAIT;
      row_base <= '0;
      hs_sr    <= '1;
      vs_sr    <= '1;
      vo_sr    <= '0;
      run_sr   <= '0;
      fs_sr    <= '0;
      rgb      <= 12'h000;
    end else begin
      if (at_origin) state <= RUN;

      // Advance one source row after every second output line; clamp keeps a
      // glitched scan from running past the last row until vblank clears it.
      if (pixel_y >= DST_H)
        row_base <= '0;
      else if ((pixel_x == DST_W - 12'd1) && pixel_y[0] && (row_base < LAST_ROW))
        row_base <= row_base + ROW_STEP;

      hs_sr  <= {hs_sr[D-2:0], hsync_in};
      vs_sr  <= {vs_sr[D-2:0], vsync_in};
      vo_sr  <= {vo_sr[D-2:0], video_on};
      run_sr <= {run_sr[D-2:0], run_eff};
      fs_sr  <= {fs_sr[D-2:0], at_origin};
      rgb    <= (vo_sr[D-2] && run_sr[D-2]) ? src : 12'h000;
    end
  end

  assign hsync_out    = hs_sr[D-1];
  assign vsync_out    = vs_sr[D-1];
  assign video_on_out = vo_sr[D-1];
  assign frame_start  = fs_sr[D-1];

endmodule
